// File: rtl/uart_fwd_buffer.sv
// uart_fwd_buffer: circular FIFO between the UART RX and TX sides, with an
// optional XOR tamper on the write path and a tx_start/tx_ready replay FSM.
//
// Ports:
//   sys_clk, rst         - clock, async active-high reset
//   rx_new_data, rx_data - received word strobe and value
//   mitm_en, mitm_mask   - XOR tamper enable and mask, applied when writing
//   tx_ready             - transmitter idle
//   tx_start, tx_data    - one-cycle start pulse and registered word to send
//   clr_overflow         - synchronous clear of the sticky overflow flag
//   fill_level, overflow - words stored, sticky "word dropped" flag
module uart_fwd_buffer #(
    parameter int NUM_DATA_BITS = 8,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          rx_new_data,
    input  logic [NUM_DATA_BITS-1:0]      rx_data,
    input  logic                          tx_ready,
    output logic                          tx_start,
    output logic [NUM_DATA_BITS-1:0]      tx_data,
    input  logic                          mitm_en,
    input  logic [NUM_DATA_BITS-1:0]      mitm_mask,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_READY
    } state_e;

    logic [NUM_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q;
    logic [AW-1:0]            rd_ptr_q;
    logic [AW:0]              fill_q;
    logic [AW:0]              fill_d;
    logic                     overflow_q;
    logic                     overflow_d;
    state_e                   state_q;
    logic                     tx_start_q;
    logic [NUM_DATA_BITS-1:0] tx_data_q;

    logic                     pop;
    logic                     full;
    logic                     wr_en;
    logic                     drop;
    logic [NUM_DATA_BITS-1:0] wr_word;

    // Pops only from IDLE; a word written this cycle is not yet counted,
    // so an empty FIFO is never bypassed.
    assign pop     = (state_q == IDLE) && (fill_q != '0) && tx_ready;
    assign full    = (fill_q == FULL_LVL);
    // A pop frees the slot the incoming word lands in (wr_ptr == rd_ptr).
    assign wr_en   = rx_new_data && (!full || pop);
    assign drop    = rx_new_data && full && !pop;
    assign wr_word = mitm_en ? (rx_data ^ mitm_mask) : rx_data;

    always_comb begin
        fill_d = fill_q;
        if (wr_en && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (!wr_en && pop) begin
            fill_d = fill_q - 1'b1;
        end
    end

    // Set wins over clear.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_start_q <= 1'b0;
                    if (pop) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        tx_start_q <= 1'b1;
                        state_q    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    tx_start_q <= 1'b0;
                    if (!tx_ready) begin
                        state_q <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    tx_start_q <= 1'b0;
                    if (tx_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign fill_level = fill_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/uart_fwd_buffer.md
Name: uart_fwd_buffer

Overview:
- Forwarding stage that sits between the RX side and the TX side of the UART driver on the MITM path.
- Captures each byte the driver receives (rx_new_data/rx_data) into a circular FIFO.
- Optionally XOR-tampers each byte with a runtime mask on the way in.
- Replays the buffered bytes to the driver's transmitter through its tx_start/tx_ready/tx_data handshake, absorbing bursts while the TX line is busy.

Parameters:
- NUM_DATA_BITS, 8, width of one UART data word.
- FIFO_DEPTH, 16, number of buffered words; must be a power of two and at least 2.

Ports:
- sys_clk  input  1  system clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- rx_new_data  input  1  one-cycle pulse from the driver: rx_data holds a new received word.
- rx_data  input  NUM_DATA_BITS  received word, valid while rx_new_data is high.
- tx_ready  input  1  driver transmitter idle and able to accept tx_start.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  output  NUM_DATA_BITS  word to transmit, registered.
- mitm_en  input  1  when high, incoming words are XORed with mitm_mask before storage.
- mitm_mask  input  NUM_DATA_BITS  tamper mask, sampled in the write cycle.
- clr_overflow  input  1  synchronous clear of the overflow flag.
- fill_level  output  $clog2(FIFO_DEPTH)+1  words currently stored, registered.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - Pointers and fill_level go to 0; FSM goes to IDLE.
  - tx_start=0, tx_data=0, overflow=0.
  - Memory contents are don't-care.
- Write path:
  - Each sys_clk edge with rx_new_data=1 stores (mitm_en ? rx_data^mitm_mask : rx_data) at wr_ptr and increments wr_ptr.
  - Pointers wrap modulo FIFO_DEPTH.
- Full:
  - A write while full and with no pop in the same cycle is discarded and sets overflow.
  - A write while full in the same cycle as a pop is accepted; fill_level is unchanged.
- Overflow flag:
  - Set has priority over clr_overflow when both occur in the same cycle.
- TX FSM states: IDLE, WAIT_BUSY, WAIT_READY.
  - IDLE: if fill_level>0 and tx_ready=1, then:
    - load tx_data <= mem[rd_ptr] and increment rd_ptr (pop);
    - drive tx_start=1 in the following cycle;
    - go to WAIT_BUSY.
  - WAIT_BUSY: tx_start=0 from the second cycle on; stay until tx_ready=0, then go to WAIT_READY.
  - WAIT_READY: stay until tx_ready=1, then go to IDLE.
  - tx_data holds its value from load until the next load.
- tx_start:
  - Exactly one cycle per popped word.
  - Never asserted while tx_ready=0.
  - Never asserted twice for one word.
- Latency:
  - rx_new_data at edge N with an empty FIFO and idle TX gives fill_level=1 after edge N.
  - The pop occurs at edge N+1; tx_start is high during the cycle after edge N+1.
- fill_level: +1 on an accepted write, −1 on a pop, unchanged on simultaneous write and pop.
- Empty: IDLE never pops while fill_level=0.
  - A write into an empty FIFO is not bypassed; it is popped at the earliest in the next cycle.
- mitm_en and mitm_mask only affect the word in the cycle it is written; already-stored words are unaffected.
- Reset mid-operation:
  - Buffered words are lost and the FSM returns to IDLE.
  - A transmission already started inside the driver is not this block's concern.

Test Plan:
- Single word: reset, tx_ready=1, pulse rx_new_data with rx_data=8'h85 -> fill_level goes 1 then 0; one tx_start pulse with tx_data=8'h85; driver model drops tx_ready for 10 bit times -> no further tx_start.
- Tamper: mitm_en=1, mitm_mask=8'hFF, rx_data=8'hF1 -> transmitted word 8'h0E; mitm_en=0 with rx_data=8'h3D -> 8'h3D.
- Burst while busy: hold tx_ready=0, write 8'h01..8'h05 -> fill_level=5, no tx_start; release tx_ready per word -> tx_data order 01,02,03,04,05, five tx_start pulses total, fill_level ends at 0.
- Overflow: tx_ready=0, write 17 words (8'h10..8'h20) with FIFO_DEPTH=16 -> fill_level=16, overflow=1, 8'h20 dropped; drain -> 8'h10..8'h1F in order; pulse clr_overflow -> overflow=0.
- Full with simultaneous pop: FIFO full, tx_ready rises, and a write lands in the same cycle as the pop -> write accepted, fill_level stays 16, overflow stays 0, the new word is transmitted last.
- Reset mid-stream: with 3 words queued and FSM in WAIT_READY, assert rst -> tx_start=0, fill_level=0, overflow=0 immediately; no tx_start after release until a new write.
